// File: rtl/reg_hazard_scoreboard.sv
// Load-use hazard scoreboard: counts in-flight loads per register and stalls decode on RAW/WAW/capacity conflicts.
// Optional stall_cycles performance counter is built only when REG_HAZARD_PERF_EN is defined.
module reg_hazard_scoreboard #(
  parameter int MAX_PER_REG = 3,
  parameter int MAX_LOADS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [15:0] dec_src_addr,
  input  logic [3:0]  dec_src_use,
  input  logic [3:0]  dec_dst_addr,
  input  logic        dec_dst_is_load,
  output logic        dec_ready,
  input  logic        ld_done_valid,
  input  logic [3:0]  ld_done_addr,
  output logic        sb_err
`ifdef REG_HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int PW = $clog2(MAX_PER_REG + 1);
  localparam int TW = $clog2(MAX_LOADS + 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PER_REG);
  localparam logic [PW-1:0] PEND_ONE  = PW'(1);
  localparam logic [TW-1:0] TOTAL_MAX = TW'(MAX_LOADS);
  localparam logic [TW-1:0] TOTAL_ONE = TW'(1);

  // Entry 0 exists only to keep indexing simple; it is never incremented.
  logic [15:0][PW-1:0] pend_q, pend_d;
  logic [TW-1:0]       total_q, total_d;
  logic                sb_err_q, sb_err_d;

  logic [15:0] busy;
  logic [15:0] inc_v;
  logic [15:0] dec_v;
  logic [PW-1:0] done_cnt, dst_cnt;
  logic done_hit, done_err;
  logic raw_haz, waw_haz, cap_haz;
  logic issue, ld_inc;

  assign done_cnt = pend_q[ld_done_addr];
  assign dst_cnt  = pend_q[dec_dst_addr];
  assign done_hit = ld_done_valid && (ld_done_addr != 4'd0) && (done_cnt != '0);
  assign done_err = ld_done_valid && (ld_done_addr != 4'd0) && (done_cnt == '0);

  // A register whose last pending load writes back now is covered by the MEM forward path.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_busy
      assign busy[gi] = (gi != 0) && (pend_q[gi] != '0) &&
                        !(ld_done_valid && (ld_done_addr == 4'(gi)) && (pend_q[gi] == PEND_ONE));
    end
  endgenerate

  always_comb begin
    raw_haz = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (dec_src_use[i] && busy[dec_src_addr[4*i +: 4]]) raw_haz = 1'b1;
    end
  end

  assign waw_haz = (dec_dst_addr != 4'd0) && !dec_dst_is_load && busy[dec_dst_addr];
  assign cap_haz = dec_dst_is_load && (dec_dst_addr != 4'd0) &&
                   (((dst_cnt == PEND_MAX) && !(done_hit && (ld_done_addr == dec_dst_addr))) ||
                    ((total_q == TOTAL_MAX) && !done_hit));

  assign dec_ready = !rst && !(raw_haz || waw_haz || cap_haz);
  assign issue     = dec_valid && dec_ready;
  assign ld_inc    = issue && dec_dst_is_load && (dec_dst_addr != 4'd0);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pend
      assign inc_v[gi]  = ld_inc && (dec_dst_addr == 4'(gi));
      assign dec_v[gi]  = done_hit && (ld_done_addr == 4'(gi));
      assign pend_d[gi] = (inc_v[gi] && !dec_v[gi] && (pend_q[gi] != PEND_MAX)) ? pend_q[gi] + PEND_ONE :
                          (dec_v[gi] && !inc_v[gi])                             ? pend_q[gi] - PEND_ONE :
                                                                                  pend_q[gi];
    end
  endgenerate

  assign total_d  = (ld_inc && !done_hit && (total_q != TOTAL_MAX)) ? total_q + TOTAL_ONE :
                    (done_hit && !ld_inc)                           ? total_q - TOTAL_ONE :
                                                                      total_q;
  assign sb_err_d = sb_err_q || done_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      total_q  <= '0;
      sb_err_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      total_q  <= total_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

`ifdef REG_HAZARD_PERF_EN
  logic [31:0] stall_q, stall_d;

  assign stall_d = (dec_valid && !dec_ready) ? stall_q + 32'd1 : stall_q;

  always_ff @(posedge clk) begin
    if (rst) stall_q <= 32'd0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/reg_hazard_scoreboard.md
# reg_hazard_scoreboard

Load-use hazard scoreboard sitting between decode and the 16-entry register file with its EXE/MEM forwarding paths. It tracks destination registers of in-flight multi-cycle loads. It stalls decode whenever a used source or destination conflicts with a pending load that forwarding cannot yet cover. Register 0 is hardwired zero and is never tracked.

## Interface
- `MAX_PER_REG`, default 3: maximum outstanding loads to one register. Per-register counter width is clog2(MAX_PER_REG+1).
- `MAX_LOADS`, default 4: maximum outstanding loads overall. The global counter has the same width rule.

Reset is synchronous and active-high, sampled on the rising edge of `clk`.

- `clk` in 1: clock
- `rst` in 1: synchronous active-high reset
- `dec_valid` in 1: decode presents an instruction
- `dec_src_addr` in 16: packed {a, b, m, p} 4-bit source addresses
- `dec_src_use` in 4: per-source use bits, same order
- `dec_dst_addr` in 4: destination register (0 = no write)
- `dec_dst_is_load` in 1: destination is written by a load
- `dec_ready` out 1: instruction may issue; issue = `dec_valid & dec_ready`
- `ld_done_valid` in 1: a load result is on the writeback port this cycle
- `ld_done_addr` in 4: register written by that load
- `sb_err` out 1: sticky protocol-error flag
- `stall_cycles` out 32: stall counter (only with `REG_HAZARD_PERF_EN`)

## Operation
- State:
  - `pend[r]`, r = 1..15, per-register outstanding-load counters.
  - `total`, global outstanding-load counter.
  - `sb_err`.
- Hazard rules. A register is *cleared this cycle* if `ld_done_valid`, `ld_done_addr == r` and `pend[r] == 1`. Writeback data reaches decode through the MEM forward path in that same cycle.
  - **RAW**: any source i with `dec_src_use[i]`, addr ≠ 0 and `pend[addr] > 0` that is not cleared this cycle → hazard.
  - **WAW, non-load**: `dec_dst_addr ≠ 0`, `!dec_dst_is_load`, `pend[dst] > 0`, not cleared this cycle → hazard. An ALU write must not be overwritten by an older load.
  - **Capacity**: `dec_dst_is_load` with dst ≠ 0, and either `pend[dst] == MAX_PER_REG` or `total == MAX_LOADS`, with no `ld_done_valid` freeing that slot this cycle → hazard.
- `dec_ready = !rst & !hazard`. It is combinational from state and current inputs and independent of `dec_valid`.
- Updates on a clock edge, not in reset:
  - An issued load with dst ≠ 0 increments `pend[dst]` and `total`.
  - A valid `ld_done` with `pend[addr] > 0` decrements `pend[addr]` and `total`.
  - Increment and decrement of the same counter in one cycle leaves it unchanged.
- Loads to r0 are never counted.
- `ld_done` with addr 0 is ignored.
- `ld_done` with `pend[addr] == 0`: no counter change, `sb_err` set to 1 until reset.
- Counters saturate and never wrap. Overflow is impossible given the capacity stall.

## Timing
- Reset values: all `pend` = 0, `total` = 0, `sb_err` = 0, `stall_cycles` = 0. `dec_ready` = 0 while `rst` is high.
- Reset mid-operation discards all tracking. Loads still in flight after reset are not counted; their `ld_done` raises `sb_err`.
- Issue decision: 0-cycle, combinational in the issue cycle.
- Counter updates become visible the cycle after issue or completion. A dependent instruction in the cycle after a load issue sees the new pending count and stalls.
- Load completing in cycle N: a dependent instruction waiting in decode gets `dec_ready = 1` in cycle N, using the MEM-forwarded value.

## Configuration
- `REG_HAZARD_PERF_EN`:
  - Defined: `stall_cycles` increments by 1 every cycle with `dec_valid & !dec_ready & !rst`, and wraps modulo 2^32.
  - Undefined: the port is absent and no counter logic is built.

## Test plan
- **Load-use hazard:** issue a load to r3; next cycle decode uses `a = r3` → `dec_ready = 0`. Assert `ld_done` for r3 → `dec_ready = 1` the same cycle, and `pend[3]` reads 0 after the edge.
- **r0 transparency:** load to r0, then a use of r0 → no stall; `total` stays 0.
- **Non-load WAW:** load to r5 pending, ALU instruction with dst r5 → stalled. With `ld_done` r5 asserted in that cycle → issues.
- **Capacity limit:** 4 loads to r1, r2, r4, r6 outstanding, then a 5th load → stalled. Assert `ld_done` for r1 in the same cycle → issues, and `total` remains 4.
- **Simultaneous issue and completion:** `pend[7] == 1`, issue a new load to r7 while `ld_done` r7 → `pend[7]` stays 1. Spurious `ld_done` r9 with `pend[9] == 0` → `sb_err = 1` until `rst`.
- **Perf counter (macro defined):** hold a stalled `dec_valid` for 5 cycles → `stall_cycles = 5`. Reset mid-stall → all outputs return to reset values the next cycle.
